// File: rtl/trace_if.sv
// trace_if: capture, trigger, readout and status signals of the trace buffer
interface trace_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 64
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W + INSTR_W + ADDR_W;
  logic               arm;
  logic               sample_en;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_we;
  logic               trig_en;
  logic [ADDR_W-1:0]  trig_pc;
  logic [AW-1:0]      post_count;
  logic               rd_en;
  logic [AW-1:0]      rd_idx;
  logic [EW-1:0]      rd_data;
  logic               rd_valid;
  logic [1:0]         state;
  logic [AW:0]        count;
  logic               triggered;
  logic               timed_out;
  logic [31:0]        cycle_cnt;
  modport master (
    output arm, sample_en, pc, instr, mem_addr, mem_wdata, mem_we,
           trig_en, trig_pc, post_count, rd_en, rd_idx,
    input  rd_data, rd_valid, state, count, triggered, timed_out, cycle_cnt
  );
  modport slave (
    input  arm, sample_en, pc, instr, mem_addr, mem_wdata, mem_we,
           trig_en, trig_pc, post_count, rd_en, rd_idx,
    output rd_data, rd_valid, state, count, triggered, timed_out, cycle_cnt
  );
endinterface

// File: rtl/trace_capture.sv
// trace_capture: circular execution-trace buffer with PC trigger, post-trigger depth and watchdog
module trace_capture #(
  parameter int ADDR_W     = 16,
  parameter int INSTR_W    = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 64,
  parameter int MAX_CYCLES = 100
) (
  input logic   clk,
  input logic   rst,
  trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + ADDR_W + DATA_W + INSTR_W + ADDR_W;
  localparam logic [31:0] WD_LIM = 32'(MAX_CYCLES - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, TRIG, DONE} state_t;
  state_t st, nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rd_data;
  logic [AW-1:0] wr_ptr, post_lat, post_cnt, phys;
  logic [AW:0]   count;
  logic [31:0]   cycle_cnt;
  logic          rd_valid, triggered, timed_out;
  logic          cap, wr, hit, wd, fin;
  always_comb begin
    cap = st == ARMED || st == TRIG;
    wr  = cap && bus.sample_en && !bus.arm;
    hit = st == ARMED && bus.sample_en && bus.trig_en && bus.pc == bus.trig_pc;
    wd  = MAX_CYCLES != 0 && cap && cycle_cnt == WD_LIM;
    fin = st == TRIG && wr && post_cnt == AW'(1);
    nxt = bus.arm ? ARMED :
          (wd || fin || (hit && post_lat == '0)) ? DONE :
          hit ? TRIG : st;
    phys = wr_ptr - count[AW-1:0] + bus.rd_idx;
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.instr, bus.pc};
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      cycle_cnt <= '0;
      post_lat  <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      timed_out <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      st       <= nxt;
      rd_valid <= st == DONE && bus.rd_en;
      if (st == DONE && bus.rd_en)
        rd_data <= {1'b0, bus.rd_idx} < count ? mem[phys] : '0;
      if (bus.arm) begin
        wr_ptr    <= '0;
        count     <= '0;
        cycle_cnt <= '0;
        post_lat  <= bus.post_count;
        post_cnt  <= '0;
        triggered <= 1'b0;
        timed_out <= 1'b0;
      end else begin
        if (cap) cycle_cnt <= cycle_cnt + 32'd1;
        if (wr) begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count == FULL ? count : count + 1'b1;
        end
        if (hit) begin
          triggered <= 1'b1;
          post_cnt  <= post_lat;
        end else if (st == TRIG && wr) post_cnt <= post_cnt - AW'(1);
        if (wd) timed_out <= 1'b1;
      end
    end
  end
  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
  assign bus.state     = st;
  assign bus.count     = count;
  assign bus.triggered = triggered;
  assign bus.timed_out = timed_out;
  assign bus.cycle_cnt = cycle_cnt;
endmodule
